wasca_onchip_mem_initiator: RTL and testbench
=============================================

# wasca_onchip_mem_initiator

Avalon-MM style initiator that drives the single-port 8192×32 on-chip memory slave from the master side. It executes one command at a time: block fill (write a pattern) or block read-sum (read words and accumulate a 32-bit checksum). It sits between the Wasca control logic and the memory's s1 port, and is used for memory clear at boot and integrity checks.

## Interface
Parameters:
- ADDR_W, 13, memory word-address width
- DATA_W, 32, memory data width
- LEN_W, 14, command length width (1..8192 words)

Ports (clock and reset first):
- clk  input  1  sole clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid & cmd_ready
- cmd_op  input  1  0 = fill, 1 = read-sum
- cmd_addr  input  ADDR_W  start word address
- cmd_len  input  LEN_W  word count; 0 = no-op
- cmd_pattern  input  DATA_W  fill data (ignored for read-sum)
- hold  input  1  pause request; freezes transfer while high
- busy  output  1  high from acceptance until done
- done  output  1  one-cycle pulse at command completion
- result  output  DATA_W  checksum of last read-sum; held until next read-sum completes
- address  output  ADDR_W  to memory
- byteenable  output  4  to memory; constant 4'hF
- chipselect  output  1  to memory
- write  output  1  to memory
- writedata  output  DATA_W  to memory
- clken  output  1  to memory clock enable
- reset_req  output  1  to memory; mirrors reset
- readdata  input  DATA_W  from memory

## Operation
- States: IDLE, FILL, READ, DRAIN, DONE.
- IDLE: cmd_ready=1. On accept: latch addr, len, pattern, op; clear accumulator. len==0 -> DONE directly. op=0 -> FILL, op=1 -> READ.
- FILL: each active cycle drives chipselect=1, write=1, address=cur_addr, writedata=cur_pattern; increments cur_addr and decrements remaining. Last word issued -> DONE.
- READ: each active cycle drives chipselect=1, write=0, address=cur_addr; sets rd_pending. Last address issued -> DRAIN.
- DRAIN: captures final readdata -> DONE.
- DONE: done=1 for one cycle; for read-sum, result takes final sum; -> IDLE.
- Active cycle = clken high = not hold and state in FILL/READ/DRAIN. clken=1 in IDLE/DONE as well; clken=0 only while hold in FILL/READ/DRAIN.
- Accumulator: wrapping 32-bit unsigned add of each captured readdata.
- Address wraps 8191 -> 0 with no error.
- chipselect=0, write=0 in IDLE, DRAIN, DONE.
- reset mid-command: state to IDLE immediately, memory strobes deasserted next edge, no done pulse, result unchanged... except reset clears result to 0.

## Timing
- Reset values: cmd_ready=1 (after reset release), busy=0, done=0, result=0, address=0, chipselect=0, write=0, writedata=0, clken=1, byteenable=4'hF.
- Memory read latency: address registered at edge N, readdata valid in cycle N+1; captured when rd_pending and clken.
- Fill of L words: L cycles in FILL plus 1 DONE; busy for L+1 cycles with no hold.
- Read-sum of L words: L READ + 1 DRAIN + 1 DONE = L+2 cycles.
- hold: each held cycle adds exactly one cycle; no word skipped, repeated, or double-counted; rd_pending preserved.
- hold in IDLE/DONE has no effect.
- cmd_valid during busy is ignored (cmd_ready=0).
- Back-to-back: next command accepted in the cycle after DONE.

## Configuration
- WASCA_MEMINIT_INCR_EN defined: fill writes cmd_pattern + i for word i (wrapping 32-bit add).
- Undefined: every fill word is cmd_pattern. Read-sum unaffected either way.

## Structure
- Package wasca_mem_pkg: state enum, ADDR_W/DATA_W/LEN_W constants, OP_FILL/OP_READSUM constants.
- Single module; no sub-module needed. The bench pairs it with a behavioural 8192×32 memory model having 1-cycle registered-address read.

## Test plan
- Fill addr=0x0010, len=4, pattern=0xA5A5_0000 -> words 0x10..0x13 written. With the macro: 0xA5A5_0000..0xA5A5_0003. Without it: all 0xA5A5_0000. done pulses 5 cycles after accept.
- Read-sum over the same region (macro on) -> result=0x9694_0006, done 6 cycles after accept.
- Wrap: fill addr=0x1FFE, len=4 -> writes to 0x1FFE, 0x1FFF, 0x0000, 0x0001; no other address touched.
- hold high 3 cycles mid read-sum of len=8 -> result equals the unheld run; completion delayed by exactly 3 cycles; clken=0 during the hold.
- len=0 -> no chipselect asserted; done 1 cycle after accept; result unchanged.
- reset asserted at word 5 of a len=16 fill -> next cycle chipselect=0, busy=0, no done pulse, words 5..15 unwritten.

Source files
------------

// File: rtl/wasca_mem_pkg.sv
// Shared constants and FSM encoding for the Wasca on-chip memory initiator.
package wasca_mem_pkg;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 14;

  localparam logic OP_FILL    = 1'b0;
  localparam logic OP_READSUM = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StRead,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/wasca_onchip_mem_initiator.sv
// Avalon-MM initiator for the 8192x32 on-chip RAM: block fill or block read-sum, one at a time.
// Define WASCA_MEMINIT_INCR_EN to make fill write pattern + word index instead of a flat pattern.
module wasca_onchip_mem_initiator #(
  parameter int unsigned ADDR_W = wasca_mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = wasca_mem_pkg::DATA_W,
  parameter int unsigned LEN_W  = wasca_mem_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_pattern,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  output logic              clken,
  output logic              reset_req,
  input  logic [DATA_W-1:0] readdata
);
  import wasca_mem_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              rd_pending_q, rd_pending_d;
  logic              in_xfer;
  logic              issuing;

  assign in_xfer = (state_q == StFill) || (state_q == StRead) || (state_q == StDrain);
  assign issuing = ((state_q == StFill) || (state_q == StRead)) && !hold;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    pat_d        = pat_q;
    acc_d        = acc_q;
    result_d     = result_q;
    rd_pending_d = rd_pending_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d       = cmd_addr;
          rem_d        = cmd_len;
          pat_d        = cmd_pattern;
          acc_d        = '0;
          rd_pending_d = 1'b0;
          if (cmd_len == '0) begin
            state_d = StDone;
          end else begin
            state_d = (cmd_op == OP_READSUM) ? StRead : StFill;
          end
        end
      end
      StFill: begin
        if (!hold) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - LEN_W'(1);
`ifdef WASCA_MEMINIT_INCR_EN
          pat_d  = pat_q + DATA_W'(1);
`else
          pat_d  = pat_q;
`endif
          if (rem_q == LEN_W'(1)) state_d = StDone;
        end
      end
      StRead: begin
        if (!hold) begin
          addr_d       = addr_q + ADDR_W'(1);
          rem_d        = rem_q - LEN_W'(1);
          rd_pending_d = 1'b1;
          // readdata belongs to the address issued on the previous active cycle
          if (rd_pending_q) acc_d = acc_q + readdata;
          if (rem_q == LEN_W'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (!hold) begin
          acc_d        = acc_q + readdata;
          result_d     = acc_q + readdata;
          rd_pending_d = 1'b0;
          state_d      = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      rem_q        <= '0;
      pat_q        <= '0;
      acc_q        <= '0;
      result_q     <= '0;
      rd_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      pat_q        <= pat_d;
      acc_q        <= acc_d;
      result_q     <= result_d;
      rd_pending_q <= rd_pending_d;
    end
  end

  always_comb begin
    cmd_ready  = (state_q == StIdle);
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
    result     = result_q;
    // Gating with reset keeps an aborted command from landing one more word.
    chipselect = issuing && !reset;
    write      = issuing && !reset && (state_q == StFill);
    address    = chipselect ? addr_q : '0;
    writedata  = write ? pat_q : '0;
    byteenable = 4'hF;
    clken      = !(hold && in_xfer);
    reset_req  = reset;
  end

endmodule

// File: tb/tb_wasca_onchip_mem_initiator.sv
// Bench for wasca_onchip_mem_initiator: 1-cycle-latency RAM model, transaction-level
// reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_wasca_onchip_mem_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [12:0] cmd_addr;
  logic [13:0] cmd_len;
  logic [31:0] cmd_pattern;
  logic        hold;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [12:0] address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic        clken;
  logic        reset_req;
  logic [31:0] readdata;

  always #5 clk = ~clk;

  wasca_onchip_mem_initiator dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .cmd_pattern (cmd_pattern),
    .hold        (hold),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .address     (address),
    .byteenable  (byteenable),
    .chipselect  (chipselect),
    .write       (write),
    .writedata   (writedata),
    .clken       (clken),
    .reset_req   (reset_req),
    .readdata    (readdata)
  );

  // RAM with registered address: data for the address seen at edge N appears in cycle N+1.
  logic [31:0] mem [0:8191];
  logic [31:0] rd_q;
  assign readdata = rd_q;

  always @(posedge clk) begin
    if (clken) begin
      if (chipselect && write) mem[address] <= writedata;
      rd_q <= mem[address];
    end
  end

`ifdef WASCA_MEMINIT_INCR_EN
  localparam logic [31:0] KInc  = 32'd1;
  localparam logic [31:0] Sum10 = 32'h9694_0006;
  localparam logic [31:0] Sum20 = 32'h0808_0824;
`else
  localparam logic [31:0] KInc  = 32'd0;
  localparam logic [31:0] Sum10 = 32'h9694_0000;
  localparam logic [31:0] Sum20 = 32'h0808_0808;
`endif

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_val(input logic [31:0] p, input int i);
`ifdef WASCA_MEMINIT_INCR_EN
    return p + 32'(i);
`else
    return p + 32'(i) * 32'd0;
`endif
  endfunction

  // Reference model: 0 = idle, 1 = transferring, 2 = completion cycle.
  int          m_st;
  int          m_work;
  int          m_issued;
  int          m_len;
  logic        m_op;
  logic [12:0] m_addr;
  logic [31:0] m_pat;
  logic [31:0] m_sum;
  logic [31:0] m_result;
  logic [31:0] shadow [0:8191];

  initial begin
    for (int i = 0; i < 8192; i++) begin
      shadow[i] = '0;
      mem[i]    = '0;
    end
    rd_q     = '0;
    m_st     = 0;
    m_work   = 0;
    m_issued = 0;
    m_len    = 0;
    m_op     = 1'b0;
    m_addr   = '0;
    m_pat    = '0;
    m_sum    = '0;
    m_result = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_st     = 0;
        m_result = '0;
      end else begin
        case (m_st)
          0: begin
            if (cmd_valid) begin
              m_op     = cmd_op;
              m_addr   = cmd_addr;
              m_len    = int'(cmd_len);
              m_pat    = cmd_pattern;
              m_issued = 0;
              // Fill needs one slot per word; read-sum one more to collect the last word.
              m_work   = m_len + (cmd_op ? 1 : 0);
              m_sum    = '0;
              for (int i = 0; i < m_len; i++) m_sum += shadow[(int'(m_addr) + i) % 8192];
              m_st     = (m_len == 0) ? 2 : 1;
            end
          end
          1: begin
            if (!hold) begin
              if (m_issued < m_len) begin
                if (!m_op) shadow[(int'(m_addr) + m_issued) % 8192] = word_val(m_pat, m_issued);
                m_issued++;
              end
              m_work--;
              if (m_work == 0) begin
                if (m_op) m_result = m_sum;
                m_st = 2;
              end
            end
          end
          default: m_st = 0;
        endcase
      end
      started = 1'b1;
    end
  end

  initial begin
    logic ecs;
    forever begin
      @(negedge clk);
      if (started) begin
        if (reset) begin
          check("cs_during_reset", 32'(chipselect), 32'd0);
          check("wr_during_reset", 32'(write), 32'd0);
          check("reset_req", 32'(reset_req), 32'd1);
        end else begin
          ecs = (m_st == 1) && !hold && (m_issued < m_len);
          check("cmd_ready", 32'(cmd_ready), 32'(m_st == 0));
          check("busy", 32'(busy), 32'(m_st != 0));
          check("done", 32'(done), 32'(m_st == 2));
          check("clken", 32'(clken), 32'(!((m_st == 1) && hold)));
          check("chipselect", 32'(chipselect), 32'(ecs));
          check("write", 32'(write), 32'(ecs && !m_op));
          check("byteenable", 32'(byteenable), 32'hF);
          check("reset_req", 32'(reset_req), 32'd0);
          check("result", result, m_result);
          if (ecs) check("address", 32'(address), 32'((int'(m_addr) + m_issued) % 8192));
          if (ecs && !m_op) check("writedata", writedata, word_val(m_pat, m_issued));
        end
      end
    end
  end

  task automatic run_cmd(input logic op, input logic [12:0] a, input logic [13:0] l,
                         input logic [31:0] p, input int keep_valid, input int hold_at,
                         input int hold_n, output int cycles);
    @(posedge clk);
    #1;
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_addr    = a;
    cmd_len     = l;
    cmd_pattern = p;
    cycles      = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (n >= keep_valid) cmd_valid = 1'b0;
      hold = (n >= hold_at) && (n < hold_at + hold_n);
      if (done) begin
        cycles = n;
        break;
      end
    end
    hold      = 1'b0;
    cmd_valid = 1'b0;
  endtask

  int cyc;

  initial begin
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = 1'b0;
    cmd_addr    = '0;
    cmd_len     = '0;
    cmd_pattern = '0;
    hold        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_cs", 32'(chipselect), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_writedata", writedata, 32'd0);
    check("rst_clken", 32'(clken), 32'd1);
    check("rst_byteenable", 32'(byteenable), 32'hF);

    // Fill with cmd_valid held into the busy period: extra offers must be ignored.
    run_cmd(1'b0, 13'h0010, 14'd4, 32'hA5A5_0000, 3, 0, 0, cyc);
    check("fill4_cycles", 32'(cyc), 32'd5);
    for (int i = 0; i < 4; i++)
      check("fill4_word", mem[16 + i], 32'hA5A5_0000 + 32'(i) * KInc);
    check("fill4_below", mem[15], 32'd0);
    check("fill4_above", mem[20], 32'd0);

    run_cmd(1'b1, 13'h0010, 14'd4, 32'hFFFF_FFFF, 1, 0, 0, cyc);
    check("sum4_cycles", 32'(cyc), 32'd6);
    check("sum4_result", result, Sum10);

    run_cmd(1'b0, 13'h1FFE, 14'd4, 32'h1234_0000, 1, 0, 0, cyc);
    check("wrap_cycles", 32'(cyc), 32'd5);
    check("wrap_1ffe", mem[8190], 32'h1234_0000);
    check("wrap_1fff", mem[8191], 32'h1234_0000 + KInc);
    check("wrap_0000", mem[0], 32'h1234_0000 + 32'd2 * KInc);
    check("wrap_0001", mem[1], 32'h1234_0000 + 32'd3 * KInc);
    check("wrap_1ffd", mem[8189], 32'd0);
    check("wrap_0002", mem[2], 32'd0);

    run_cmd(1'b0, 13'h0020, 14'd8, 32'h0101_0101, 1, 0, 0, cyc);
    check("fill8_cycles", 32'(cyc), 32'd9);

    run_cmd(1'b1, 13'h0020, 14'd8, 32'h0, 1, 0, 0, cyc);
    check("sum8_cycles", 32'(cyc), 32'd10);
    check("sum8_result", result, Sum20);

    run_cmd(1'b1, 13'h0020, 14'd8, 32'h0, 1, 4, 3, cyc);
    check("sum8_hold_cycles", 32'(cyc), 32'd13);
    check("sum8_hold_result", result, Sum20);

    // Hold across the final capture cycle.
    run_cmd(1'b1, 13'h0020, 14'd8, 32'h0, 1, 9, 2, cyc);
    check("sum8_drainhold_cycles", 32'(cyc), 32'd12);
    check("sum8_drainhold_result", result, Sum20);

    run_cmd(1'b1, 13'h0040, 14'd0, 32'h0, 1, 0, 0, cyc);
    check("len0_cycles", 32'(cyc), 32'd1);
    check("len0_result", result, Sum20);

    // Abort a 16-word fill while word 5 is on the bus.
    @(posedge clk);
    #1;
    cmd_valid   = 1'b1;
    cmd_op      = 1'b0;
    cmd_addr    = 13'h0100;
    cmd_len     = 14'd16;
    cmd_pattern = 32'hCAFE_0000;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_cs", 32'(chipselect), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_word4", mem[256 + 4], 32'hCAFE_0000 + 32'd4 * KInc);
    for (int i = 5; i < 16; i++) check("abort_unwritten", mem[256 + i], 32'd0);

    run_cmd(1'b1, 13'h0010, 14'd4, 32'h0, 1, 0, 0, cyc);
    check("post_abort_cycles", 32'(cyc), 32'd6);
    check("post_abort_result", result, Sum10);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
